// File: rtl/spi_pkg.sv
// spi_pkg: SPI frame width, counter width and FSM state type shared by the SPI master and slave.
package spi_pkg;
    localparam int DATA_W = 16;
    localparam int CNT_W = $clog2(DATA_W) + 1;
    typedef enum logic [2:0] {IDLE, READY, SHIFT, DONE, WAIT_CS} spi_state_t;
endpackage

// File: rtl/spi_slave_shifter.sv
// spi_slave_shifter: indexed rx/tx shift registers and the bit counter for one SPI frame.
module spi_slave_shifter #(
    parameter int DATA_W = spi_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic              shift,
    input  logic              mosi,
    input  logic [DATA_W-1:0] load_data,
    output logic              tx_bit,
    output logic              last_bit,
    output logic [DATA_W-1:0] rx_word
);
    import spi_pkg::*;
    localparam int CW = $clog2(DATA_W) + 1;
    logic [CW-1:0] cnt;
    logic [CW-2:0] idx;
    logic [DATA_W-1:0] rx_shift, tx_shift;
    assign idx = cnt[CW-2:0];
    assign tx_bit = tx_shift[idx];
    assign last_bit = cnt == CW'(DATA_W - 1);
    assign rx_word = rx_shift;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
        end else begin
            if (clr) cnt <= '0;
            else if (shift) cnt <= cnt + CW'(1);
            if (load) tx_shift <= load_data;
            if (shift) rx_shift[idx] <= mosi;
        end
    end
endmodule

// File: rtl/spi_slave_port.sv
// spi_slave_port: clk-synchronous SPI slave; one bit per clk, LSB-first frames with a preloaded response.
module spi_slave_port #(
    parameter int DATA_W = spi_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_in,
    input  logic              mosi_in,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              miso_out,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              tx_pending,
    output logic              frame_err,
    output logic              tx_underrun
);
    import spi_pkg::*;
    spi_state_t state, nxt;
    logic [DATA_W-1:0] tx_buf, rx_word;
    logic ready_go, shift_go, abort, tx_bit, last_bit;
    assign ready_go = state == READY && cs_in;
    assign shift_go = state == SHIFT && cs_in;
    assign abort = state == SHIFT && !cs_in;
    assign busy = state != IDLE;
    spi_slave_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk(clk),
        .rst(rst),
        .clr(ready_go || abort),
        .load(ready_go),
        .shift(shift_go),
        .mosi(mosi_in),
        .load_data(tx_pending ? tx_buf : '0),
        .tx_bit(tx_bit),
        .last_bit(last_bit),
        .rx_word(rx_word)
    );
    always_ff @(posedge clk) state <= rst ? IDLE : nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = cs_in ? READY : IDLE;
            READY:   nxt = cs_in ? SHIFT : IDLE;
            SHIFT:   nxt = !cs_in ? IDLE : last_bit ? DONE : SHIFT;
            DONE:    nxt = cs_in ? WAIT_CS : IDLE;
            WAIT_CS: nxt = cs_in ? WAIT_CS : IDLE;
            default: nxt = IDLE;
        endcase
    end
    // A tx_load colliding with the READY copy wins: the old word goes out, the new one stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_buf <= '0;
            tx_pending <= 1'b0;
            miso_out <= 1'b0;
            rx_data <= '0;
            rx_valid <= 1'b0;
            frame_err <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            miso_out <= shift_go ? tx_bit : 1'b0;
            rx_valid <= state == DONE;
            frame_err <= abort;
            tx_underrun <= ready_go && !tx_pending;
            if (state == DONE) rx_data <= rx_word;
            if (tx_load) begin
                tx_buf <= tx_data;
                tx_pending <= 1'b1;
            end else if (ready_go) begin
                tx_pending <= 1'b0;
            end
        end
    end
endmodule
